// File: rtl/present_core_param.sv
`default_nettype none
// ------------------------------------------------------------------------
// present_core_param : iterative PRESENT-80/128 block cipher, one round per
//                      clock, runtime encrypt/decrypt, valid/ready result hold
// Revision : 1.0
// ------------------------------------------------------------------------
module present_core_param #(
  parameter int g_KeyWidth   = 80,
  parameter bit g_HasDecrypt = 1'b1
) (
  input  logic                  Clk_ik,
  input  logic                  Reset_irn,
  input  logic [g_KeyWidth-1:0] Key_ib,
  input  logic [63:0]           Text_ib,
  input  logic                  Decrypt_i,
  input  logic                  Start_i,
  output logic                  Ready_o,
  output logic [63:0]           Text_ob,
  output logic                  Valid_o,
  input  logic                  Ack_i
);

  localparam logic [1:0] c_StIdle   = 2'd0;
  localparam logic [1:0] c_StKeyFwd = 2'd1;
  localparam logic [1:0] c_StRound  = 2'd2;
  localparam logic [1:0] c_StHold   = 2'd3;

  localparam logic [4:0] c_FirstRound = 5'd1;
  localparam logic [4:0] c_LastRound  = 5'd31;
  localparam int         c_KeyMsb     = g_KeyWidth - 1;

  logic [1:0]            r_state;
  logic [1:0]            w_stateNext;
  logic [4:0]            r_round;
  logic [63:0]           r_data;
  logic [g_KeyWidth-1:0] r_key;
  logic                  r_decrypt;
  logic [63:0]           r_textOut;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_startDec;
  logic [g_KeyWidth-1:0] w_keyUpd;
  logic [g_KeyWidth-1:0] w_keyPrev;
  logic [63:0]           w_encData;
  logic [63:0]           w_decData;

  function automatic logic [3:0] sBox(input logic [3:0] x);
    case (x)
      4'h0: sBox = 4'hC;  4'h1: sBox = 4'h5;  4'h2: sBox = 4'h6;  4'h3: sBox = 4'hB;
      4'h4: sBox = 4'h9;  4'h5: sBox = 4'h0;  4'h6: sBox = 4'hA;  4'h7: sBox = 4'hD;
      4'h8: sBox = 4'h3;  4'h9: sBox = 4'hE;  4'hA: sBox = 4'hF;  4'hB: sBox = 4'h8;
      4'hC: sBox = 4'h4;  4'hD: sBox = 4'h7;  4'hE: sBox = 4'h1;  default: sBox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] invSBox(input logic [3:0] x);
    case (x)
      4'h0: invSBox = 4'h5;  4'h1: invSBox = 4'hE;  4'h2: invSBox = 4'hF;  4'h3: invSBox = 4'h8;
      4'h4: invSBox = 4'hC;  4'h5: invSBox = 4'h1;  4'h6: invSBox = 4'h2;  4'h7: invSBox = 4'hD;
      4'h8: invSBox = 4'hB;  4'h9: invSBox = 4'h4;  4'hA: invSBox = 4'h6;  4'hB: invSBox = 4'h3;
      4'hC: invSBox = 4'h0;  4'hD: invSBox = 4'h7;  4'hE: invSBox = 4'h9;  default: invSBox = 4'hA;
    endcase
  endfunction

  function automatic logic [63:0] sLayer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sBox(x[4*i +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] invSLayer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = invSBox(x[4*i +: 4]);
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 is fixed.
  function automatic logic [63:0] pLayer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [63:0] invPLayer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
    y[63] = x[63];
    return y;
  endfunction

  // Forward and inverse key schedule for the selected key width.
  generate
    if (g_KeyWidth == 80) begin : g_key80
      logic [79:0] w_rot;
      always_comb begin
        w_rot          = {r_key[18:0], r_key[79:19]};
        w_rot[79:76]   = sBox(w_rot[79:76]);
        w_rot[19:15]   = w_rot[19:15] ^ r_round;
        w_keyUpd       = w_rot;
      end
      if (g_HasDecrypt) begin : g_inv80
        logic [79:0] w_mix;
        always_comb begin
          w_mix          = r_key;
          w_mix[19:15]   = w_mix[19:15] ^ r_round;
          w_mix[79:76]   = invSBox(w_mix[79:76]);
          w_keyPrev      = {w_mix[60:0], w_mix[79:61]};
        end
      end else begin : g_noInv80
        assign w_keyPrev = '0;
      end
    end else if (g_KeyWidth == 128) begin : g_key128
      logic [127:0] w_rot;
      always_comb begin
        w_rot            = {r_key[66:0], r_key[127:67]};
        w_rot[127:124]   = sBox(w_rot[127:124]);
        w_rot[123:120]   = sBox(w_rot[123:120]);
        w_rot[66:62]     = w_rot[66:62] ^ r_round;
        w_keyUpd         = w_rot;
      end
      if (g_HasDecrypt) begin : g_inv128
        logic [127:0] w_mix;
        always_comb begin
          w_mix            = r_key;
          w_mix[66:62]     = w_mix[66:62] ^ r_round;
          w_mix[127:124]   = invSBox(w_mix[127:124]);
          w_mix[123:120]   = invSBox(w_mix[123:120]);
          w_keyPrev        = {w_mix[60:0], w_mix[127:61]};
        end
      end else begin : g_noInv128
        assign w_keyPrev = '0;
      end
    end else begin : g_badKeyWidth
      $error("present_core_param: g_KeyWidth must be 80 or 128");
      assign w_keyUpd  = '0;
      assign w_keyPrev = '0;
    end
  endgenerate

  assign w_encData = pLayer(sLayer(r_data ^ r_key[c_KeyMsb -: 64]));

  generate
    if (g_HasDecrypt) begin : g_decPath
      assign w_decData = invSLayer(invPLayer(r_data)) ^ w_keyPrev[c_KeyMsb -: 64];
    end else begin : g_noDecPath
      assign w_decData = '0;
    end
  endgenerate

  assign w_startDec = Decrypt_i & g_HasDecrypt;
  assign w_accept   = Start_i & Ready_o;

  always_ff @(posedge Clk_ik or negedge Reset_irn) begin
    if (!Reset_irn) r_state <= c_StIdle;
    else            r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_StIdle:   if (w_accept) w_stateNext = w_startDec ? c_StKeyFwd : c_StRound;
      c_StKeyFwd: if (r_round == c_LastRound) w_stateNext = c_StRound;
      c_StRound: begin
        if (r_decrypt ? (r_round == c_FirstRound) : (r_round == c_LastRound))
          w_stateNext = c_StHold;
      end
      c_StHold: begin
        if (w_accept)   w_stateNext = w_startDec ? c_StKeyFwd : c_StRound;
        else if (Ack_i) w_stateNext = c_StIdle;
      end
      default:    w_stateNext = c_StIdle;
    endcase
  end

  always_comb begin
    Ready_o = 1'b0;
    case (r_state)
      c_StIdle: Ready_o = 1'b1;
      c_StHold: Ready_o = Ack_i;
      default:  Ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge Clk_ik or negedge Reset_irn) begin
    if (!Reset_irn) begin
      r_round   <= '0;
      r_data    <= '0;
      r_key     <= '0;
      r_decrypt <= 1'b0;
      r_textOut <= '0;
      r_valid   <= 1'b0;
    end else if (w_accept) begin
      r_data    <= Text_ib;
      r_key     <= Key_ib;
      r_round   <= c_FirstRound;
      r_decrypt <= w_startDec;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        c_StKeyFwd: begin
          r_key <= w_keyUpd;
          // Last rewind step also whitens the captured ciphertext with K32.
          if (r_round == c_LastRound) r_data  <= r_data ^ w_keyUpd[c_KeyMsb -: 64];
          else                        r_round <= r_round + 5'd1;
        end
        c_StRound: begin
          if (r_decrypt) begin
            r_data <= w_decData;
            r_key  <= w_keyPrev;
            if (r_round == c_FirstRound) begin
              r_textOut <= w_decData;
              r_valid   <= 1'b1;
            end else begin
              r_round <= r_round - 5'd1;
            end
          end else begin
            r_data <= w_encData;
            r_key  <= w_keyUpd;
            if (r_round == c_LastRound) begin
              r_textOut <= w_encData ^ w_keyUpd[c_KeyMsb -: 64];
              r_valid   <= 1'b1;
            end else begin
              r_round <= r_round + 5'd1;
            end
          end
        end
        c_StHold: if (Ack_i) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign Text_ob = r_textOut;
  assign Valid_o = r_valid;

endmodule
`default_nettype wire
